punc_control_fsm: RTL and testbench
===================================

Name: punc_control_fsm

Overview:
- Control unit for the PUnC LC3 processor.
- Consumes the instruction register and N/Z/P flags from the PUnC datapath and drives every datapath select, load and write-enable.
- Multi-cycle FSM: FETCH, DECODE, EXEC, with an EXEC2 state for indirect memory ops and a sticky HALT.

Parameters:
- HALT_VECT, 8'h25, trap vector that halts; any other TRAP vector is a NOP.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- ir  in  16  instruction register contents from datapath
- n  in  1  condition flag N; z in 1 flag Z; p in 1 flag P
- PC_data_sel  out  1  0=PC adder, 1=BaseR (rd0)
- PC_add_sel  out  1  0=PCoffset11, 1=PCoffset9
- PC_ld, PC_clr, PC_inc, IR_ld  out  1 each  PC / IR controls
- addr_MEM_sel  out  2  00=PC, 01=ALU, 10=store reg
- w_en_MEM  out  1  memory write enable
- w_RF_sel  out  2  00=PC, 01=MEM data, 10=ALU
- r_addr_0_RF, r_addr_1_RF, w_addr_RF  out  3 each  RF addresses
- w_en_RF  out  1  RF write enable
- sext_sel  out  2  00=imm5, 01=off6, 10=off9, 11=off11
- A_sel  out  1  0=PC, 1=rd0
- B_sel  out  1  0=rd1, 1=sext
- ALU_sel  out  2  00=ADD, 01=AND, 10=NOT A, 11=PASS A
- NZP_sel  out  1  0=ALU result, 1=MEM data
- N_ld, Z_ld, P_ld  out  1 each  flag loads (always driven together)
- store_ld  out  1  latch MEM data into store reg
- halted  out  1  high in HALT

Behaviour:
- State register is the only sequential element; all outputs are combinational from state and ir.
- Reset (rst=0, async): state=FETCH. All outputs are forced 0 while rst=0. halted=0.
- Outputs not listed for a state are 0.
- FETCH (1 cycle):
  - addr_MEM_sel=00, IR_ld=1, PC_inc=1.
  - Next state DECODE.
- DECODE (1 cycle): no enables asserted.
  - Opcode 1111 with ir[7:0]==HALT_VECT goes to HALT.
  - Every other opcode goes to EXEC.
- EXEC, 1 cycle, then FETCH unless noted. Addressing: DR=ir[11:9], SR1/BaseR=ir[8:6], SR2=ir[2:0], SR(store)=ir[11:9].
  - ADD(0001)/AND(0101): A_sel=1, B_sel=ir[5], sext_sel=00, ALU_sel=ADD/AND, w_RF_sel=10, w_en_RF=1, flags loaded with NZP_sel=0.
  - NOT(1001): ALU_sel=10, A_sel=1, write DR, flags loaded with NZP_sel=0.
  - BR(0000): PC_ld=1, PC_data_sel=0, PC_add_sel=1 only if (ir[11]&n)|(ir[10]&z)|(ir[9]&p); otherwise no enables.
  - JMP(1100): PC_ld=1, PC_data_sel=1, r_addr_0_RF=BaseR.
  - JSR(0100): w_addr_RF=7, w_RF_sel=00, w_en_RF=1, PC_ld=1.
    - ir[11]=1: PC_data_sel=0, PC_add_sel=0.
    - ir[11]=0: PC_data_sel=1 (BaseR read pre-write, so JSRR R7 uses old R7).
  - LD(0010)/ST(0011)/LDI(1010)/STI(1011): address = PC+off9 via A_sel=0, B_sel=1, sext_sel=10, ALU_sel=ADD, addr_MEM_sel=01.
  - LDR(0110)/STR(0111): address = BaseR+off6 (A_sel=1, sext_sel=01).
  - Loads (LD, LDR): w_RF_sel=01, w_en_RF=1, flags loaded with NZP_sel=1.
  - Stores (ST, STR): r_addr_1_RF=SR, w_en_MEM=1.
  - LDI/STI: store_ld=1, next state EXEC2.
  - LEA(1110): PC+off9 through ALU, w_RF_sel=10, write DR; flags not loaded.
  - TRAP with vector other than HALT_VECT, RTI(1000), reserved(1101): no enables.
- EXEC2 (LDI/STI only): addr_MEM_sel=10.
  - LDI: write DR from MEM, flags loaded with NZP_sel=1.
  - STI: w_en_MEM=1 with r_addr_1_RF=SR.
  - Next state FETCH.
- Latency: 3 cycles per instruction; LDI/STI take 4.
- HALT: absorbing, halted=1, no enables; only rst exits it.
- Reset mid-instruction abandons the instruction; no enable may pulse on the deassertion edge.

Optional Feature:
- PUNC_ILLEGAL_TRAP_EN.
- Defined: adds output illegal_op (1 bit). Opcodes 1000 and 1101 go DECODE->HALT with illegal_op=1 while in HALT. illegal_op clears only on reset.
- Undefined: port absent; those opcodes execute as NOPs.

Test Plan:
- Reset then ir=16'h1261 (ADD R1,R1,#1): FETCH IR_ld/PC_inc, DECODE idle, EXEC w_en_RF=1, w_addr_RF=1, B_sel=1, N/Z/P_ld=1; back to FETCH on cycle 4.
- ir=16'h0402 (BRz) with z=1: PC_ld=1, PC_add_sel=1. Repeat with z=0: PC_ld=0.
- ir=16'hA201 (LDI R1): EXEC store_ld=1, addr_MEM_sel=01. EXEC2 addr_MEM_sel=10, w_RF_sel=01, NZP_sel=1. Total 4 cycles.
- ir=16'h41C0 (JSRR R7): w_addr_RF=7, PC_data_sel=1, r_addr_0_RF=7, PC_ld and w_en_RF in the same cycle.
- ir=16'hF025: halted=1 after DECODE and stays high 20 cycles. Assert rst low mid-HALT: all outputs 0 immediately, then FETCH.
- ir=16'hF020: NOP, returns to FETCH. ir=16'hD000: NOP without PUNC_ILLEGAL_TRAP_EN; halted=1 and illegal_op=1 with it.

Source files
------------

// File: rtl/punc_control_fsm.sv
// PUnC LC3 control unit: FETCH/DECODE/EXEC(/EXEC2) sequencer driving all datapath controls.
// Optional define PUNC_ILLEGAL_TRAP_EN adds illegal_op and halts on RTI/reserved opcodes.
module punc_control_fsm #(
    parameter logic [7:0] HALT_VECT = 8'h25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    output logic        PC_data_sel,
    output logic        PC_add_sel,
    output logic        PC_ld,
    output logic        PC_clr,
    output logic        PC_inc,
    output logic        IR_ld,
    output logic [1:0]  addr_MEM_sel,
    output logic        w_en_MEM,
    output logic [1:0]  w_RF_sel,
    output logic [2:0]  r_addr_0_RF,
    output logic [2:0]  r_addr_1_RF,
    output logic [2:0]  w_addr_RF,
    output logic        w_en_RF,
    output logic [1:0]  sext_sel,
    output logic        A_sel,
    output logic        B_sel,
    output logic [1:0]  ALU_sel,
    output logic        NZP_sel,
    output logic        N_ld,
    output logic        Z_ld,
    output logic        P_ld,
    output logic        store_ld,
    output logic        halted
`ifdef PUNC_ILLEGAL_TRAP_EN
    ,
    output logic        illegal_op
`endif
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_HALT, S_HALT_ILL
    } state_t;

    typedef enum logic [3:0] {
        OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011,
        OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111,
        OP_RTI = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011,
        OP_JMP = 4'b1100, OP_RES = 4'b1101, OP_LEA = 4'b1110, OP_TRAP = 4'b1111
    } opcode_t;

    state_t  state, next_state;
    opcode_t op;
    logic [2:0] dr, sr1, sr2;
    logic    br_taken;
    logic    flags_ld;

    assign op       = opcode_t'(ir[15:12]);
    assign dr       = ir[11:9];
    assign sr1      = ir[8:6];
    assign sr2      = ir[2:0];
    assign br_taken = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= next_state;
    end

    always_comb begin
        next_state   = state;
        PC_data_sel  = 1'b0;
        PC_add_sel   = 1'b0;
        PC_ld        = 1'b0;
        PC_clr       = 1'b0;
        PC_inc       = 1'b0;
        IR_ld        = 1'b0;
        addr_MEM_sel = 2'b00;
        w_en_MEM     = 1'b0;
        w_RF_sel     = 2'b00;
        r_addr_0_RF  = '0;
        r_addr_1_RF  = '0;
        w_addr_RF    = '0;
        w_en_RF      = 1'b0;
        sext_sel     = 2'b00;
        A_sel        = 1'b0;
        B_sel        = 1'b0;
        ALU_sel      = 2'b00;
        NZP_sel      = 1'b0;
        store_ld     = 1'b0;
        halted       = 1'b0;
        flags_ld     = 1'b0;
`ifdef PUNC_ILLEGAL_TRAP_EN
        illegal_op   = 1'b0;
`endif
        // Gating on rst keeps every control low for the whole reset window.
        if (rst) begin
            case (state)
                S_FETCH: begin
                    IR_ld      = 1'b1;
                    PC_inc     = 1'b1;
                    next_state = S_DECODE;
                end
                S_DECODE: begin
                    if (op == OP_TRAP && ir[7:0] == HALT_VECT)
                        next_state = S_HALT;
`ifdef PUNC_ILLEGAL_TRAP_EN
                    else if (op == OP_RTI || op == OP_RES)
                        next_state = S_HALT_ILL;
`endif
                    else
                        next_state = S_EXEC;
                end
                S_EXEC: begin
                    next_state = S_FETCH;
                    case (op)
                        OP_ADD, OP_AND, OP_NOT: begin
                            r_addr_0_RF = sr1;
                            A_sel       = 1'b1;
                            w_RF_sel    = 2'b10;
                            w_addr_RF   = dr;
                            w_en_RF     = 1'b1;
                            flags_ld    = 1'b1;
                            if (op == OP_NOT) begin
                                ALU_sel = 2'b10;
                            end else begin
                                r_addr_1_RF = sr2;
                                B_sel       = ir[5];
                                ALU_sel     = (op == OP_AND) ? 2'b01 : 2'b00;
                            end
                        end
                        OP_BR: begin
                            if (br_taken) begin
                                PC_ld      = 1'b1;
                                PC_add_sel = 1'b1;
                            end
                        end
                        OP_JMP: begin
                            PC_ld       = 1'b1;
                            PC_data_sel = 1'b1;
                            r_addr_0_RF = sr1;
                        end
                        OP_JSR: begin
                            // BaseR is read this same cycle, before R7 is overwritten.
                            w_addr_RF = 3'd7;
                            w_en_RF   = 1'b1;
                            PC_ld     = 1'b1;
                            if (!ir[11]) begin
                                PC_data_sel = 1'b1;
                                r_addr_0_RF = sr1;
                            end
                        end
                        OP_LD, OP_ST, OP_LDI, OP_STI, OP_LDR, OP_STR: begin
                            B_sel        = 1'b1;
                            addr_MEM_sel = 2'b01;
                            if (op == OP_LDR || op == OP_STR) begin
                                A_sel       = 1'b1;
                                sext_sel    = 2'b01;
                                r_addr_0_RF = sr1;
                            end else begin
                                sext_sel = 2'b10;
                            end
                            case (op)
                                OP_LD, OP_LDR: begin
                                    w_RF_sel  = 2'b01;
                                    w_addr_RF = dr;
                                    w_en_RF   = 1'b1;
                                    NZP_sel   = 1'b1;
                                    flags_ld  = 1'b1;
                                end
                                OP_ST, OP_STR: begin
                                    r_addr_1_RF = dr;
                                    w_en_MEM    = 1'b1;
                                end
                                default: begin
                                    store_ld   = 1'b1;
                                    next_state = S_EXEC2;
                                end
                            endcase
                        end
                        OP_LEA: begin
                            B_sel     = 1'b1;
                            sext_sel  = 2'b10;
                            w_RF_sel  = 2'b10;
                            w_addr_RF = dr;
                            w_en_RF   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_EXEC2: begin
                    next_state   = S_FETCH;
                    addr_MEM_sel = 2'b10;
                    if (op == OP_LDI) begin
                        w_RF_sel  = 2'b01;
                        w_addr_RF = dr;
                        w_en_RF   = 1'b1;
                        NZP_sel   = 1'b1;
                        flags_ld  = 1'b1;
                    end else begin
                        r_addr_1_RF = dr;
                        w_en_MEM    = 1'b1;
                    end
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                S_HALT_ILL: begin
                    halted = 1'b1;
`ifdef PUNC_ILLEGAL_TRAP_EN
                    illegal_op = 1'b1;
`endif
                end
                default: next_state = S_FETCH;
            endcase
        end
        N_ld = flags_ld;
        Z_ld = flags_ld;
        P_ld = flags_ld;
    end

endmodule

// File: tb/tb_punc_control_fsm.sv
// Self-checking bench for punc_control_fsm: per-cycle model comparison plus directed literal checks.
module tb_punc_control_fsm;

    typedef struct packed {
        logic       PC_data_sel;
        logic       PC_add_sel;
        logic       PC_ld;
        logic       PC_clr;
        logic       PC_inc;
        logic       IR_ld;
        logic [1:0] addr_MEM_sel;
        logic       w_en_MEM;
        logic [1:0] w_RF_sel;
        logic [2:0] r_addr_0_RF;
        logic [2:0] r_addr_1_RF;
        logic [2:0] w_addr_RF;
        logic       w_en_RF;
        logic [1:0] sext_sel;
        logic       A_sel;
        logic       B_sel;
        logic [1:0] ALU_sel;
        logic       NZP_sel;
        logic       N_ld;
        logic       Z_ld;
        logic       P_ld;
        logic       store_ld;
        logic       halted;
    } ctl_t;

    logic clk = 1'b0;
    logic rst;
    logic [15:0] ir;
    logic n, z, p;
    logic PC_data_sel, PC_add_sel, PC_ld, PC_clr, PC_inc, IR_ld;
    logic [1:0] addr_MEM_sel, w_RF_sel, sext_sel, ALU_sel;
    logic w_en_MEM, w_en_RF, A_sel, B_sel, NZP_sel, N_ld, Z_ld, P_ld, store_ld, halted;
    logic [2:0] r_addr_0_RF, r_addr_1_RF, w_addr_RF;
`ifdef PUNC_ILLEGAL_TRAP_EN
    logic illegal_op;
`endif
    ctl_t dut_v;

    int tests = 0;
    int fails = 0;
    int  m_step = 0;
    bit  m_halt = 1'b0;
    bit  m_ill  = 1'b0;

    always #5 clk = ~clk;

    punc_control_fsm #(.HALT_VECT(8'h25)) dut (
        .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
        .PC_data_sel(PC_data_sel), .PC_add_sel(PC_add_sel), .PC_ld(PC_ld),
        .PC_clr(PC_clr), .PC_inc(PC_inc), .IR_ld(IR_ld),
        .addr_MEM_sel(addr_MEM_sel), .w_en_MEM(w_en_MEM), .w_RF_sel(w_RF_sel),
        .r_addr_0_RF(r_addr_0_RF), .r_addr_1_RF(r_addr_1_RF), .w_addr_RF(w_addr_RF),
        .w_en_RF(w_en_RF), .sext_sel(sext_sel), .A_sel(A_sel), .B_sel(B_sel),
        .ALU_sel(ALU_sel), .NZP_sel(NZP_sel), .N_ld(N_ld), .Z_ld(Z_ld), .P_ld(P_ld),
        .store_ld(store_ld), .halted(halted)
`ifdef PUNC_ILLEGAL_TRAP_EN
        , .illegal_op(illegal_op)
`endif
    );

    assign dut_v = {PC_data_sel, PC_add_sel, PC_ld, PC_clr, PC_inc, IR_ld, addr_MEM_sel,
                    w_en_MEM, w_RF_sel, r_addr_0_RF, r_addr_1_RF, w_addr_RF, w_en_RF,
                    sext_sel, A_sel, B_sel, ALU_sel, NZP_sel, N_ld, Z_ld, P_ld,
                    store_ld, halted};

    // Expected controls from the instruction's phase and the ISA rules.
    function automatic ctl_t model_out(input bit rv, input int stp, input bit hl,
                                       input logic [15:0] i, input logic fn, fz, fp);
        ctl_t e;
        logic [3:0] opc;
        e   = '0;
        opc = i[15:12];
        if (!rv) return e;
        if (hl) begin e.halted = 1'b1; return e; end
        if (stp == 0) begin e.IR_ld = 1'b1; e.PC_inc = 1'b1; return e; end
        if (stp == 1) return e;
        if (stp == 3) begin
            e.addr_MEM_sel = 2'b10;
            if (opc == 4'hA) begin
                e.w_RF_sel = 2'b01; e.w_addr_RF = i[11:9]; e.w_en_RF = 1'b1;
                e.NZP_sel = 1'b1; {e.N_ld, e.Z_ld, e.P_ld} = 3'b111;
            end else begin
                e.r_addr_1_RF = i[11:9]; e.w_en_MEM = 1'b1;
            end
            return e;
        end
        if (opc == 4'h1 || opc == 4'h5 || opc == 4'h9) begin
            e.A_sel = 1'b1; e.r_addr_0_RF = i[8:6];
            e.w_RF_sel = 2'b10; e.w_addr_RF = i[11:9]; e.w_en_RF = 1'b1;
            {e.N_ld, e.Z_ld, e.P_ld} = 3'b111;
            if (opc == 4'h9) e.ALU_sel = 2'b10;
            else begin
                e.B_sel = i[5]; e.r_addr_1_RF = i[2:0];
                e.ALU_sel = (opc == 4'h5) ? 2'b01 : 2'b00;
            end
        end else if (opc == 4'h0) begin
            if ((i[11] && fn) || (i[10] && fz) || (i[9] && fp)) begin
                e.PC_ld = 1'b1; e.PC_add_sel = 1'b1;
            end
        end else if (opc == 4'hC) begin
            e.PC_ld = 1'b1; e.PC_data_sel = 1'b1; e.r_addr_0_RF = i[8:6];
        end else if (opc == 4'h4) begin
            e.w_addr_RF = 3'd7; e.w_en_RF = 1'b1; e.PC_ld = 1'b1;
            if (!i[11]) begin e.PC_data_sel = 1'b1; e.r_addr_0_RF = i[8:6]; end
        end else if (opc inside {4'h2, 4'h3, 4'hA, 4'hB, 4'h6, 4'h7}) begin
            e.B_sel = 1'b1; e.addr_MEM_sel = 2'b01;
            if (opc == 4'h6 || opc == 4'h7) begin
                e.A_sel = 1'b1; e.sext_sel = 2'b01; e.r_addr_0_RF = i[8:6];
            end else e.sext_sel = 2'b10;
            if (opc == 4'h2 || opc == 4'h6) begin
                e.w_RF_sel = 2'b01; e.w_addr_RF = i[11:9]; e.w_en_RF = 1'b1;
                e.NZP_sel = 1'b1; {e.N_ld, e.Z_ld, e.P_ld} = 3'b111;
            end else if (opc == 4'h3 || opc == 4'h7) begin
                e.r_addr_1_RF = i[11:9]; e.w_en_MEM = 1'b1;
            end else e.store_ld = 1'b1;
        end else if (opc == 4'hE) begin
            e.B_sel = 1'b1; e.sext_sel = 2'b10; e.w_RF_sel = 2'b10;
            e.w_addr_RF = i[11:9]; e.w_en_RF = 1'b1;
        end
        return e;
    endfunction

    task automatic model_advance();
        if (!rst) begin
            m_step = 0; m_halt = 1'b0; m_ill = 1'b0;
        end else if (!m_halt) begin
            case (m_step)
                0: m_step = 1;
                1: begin
                    if (ir[15:12] == 4'hF && ir[7:0] == 8'h25) m_halt = 1'b1;
`ifdef PUNC_ILLEGAL_TRAP_EN
                    else if (ir[15:12] == 4'h8 || ir[15:12] == 4'hD) begin
                        m_halt = 1'b1; m_ill = 1'b1;
                    end
`endif
                    else m_step = 2;
                end
                2: m_step = (ir[15:12] == 4'hA || ir[15:12] == 4'hB) ? 3 : 0;
                default: m_step = 0;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: compare at negedge, advance the model at posedge, return at posedge+1.
    task automatic tick();
        ctl_t e;
        @(negedge clk);
        e = model_out(rst, m_step, m_halt, ir, n, z, p);
        chk($sformatf("cycle step=%0d ir=%h", m_step, ir), 64'(dut_v), 64'(e));
`ifdef PUNC_ILLEGAL_TRAP_EN
        chk("illegal_op", 64'(illegal_op), 64'(m_ill && rst));
`endif
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic run(input logic [15:0] iv, input logic [2:0] nzp, input int exp_len);
        int cnt;
        ir = iv; {n, z, p} = nzp;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (m_step != 0 && !m_halt && cnt < 8);
        chk($sformatf("latency ir=%h", iv), 64'(cnt), 64'(exp_len));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("reset_outputs_zero", 64'(dut_v), 64'd0);
        m_step = 0; m_halt = 1'b0; m_ill = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("fetch_after_reset", 64'({dut_v.IR_ld, dut_v.PC_inc}), 64'(2'b11));
    endtask

    initial begin
        rst = 1'b0; ir = '0; {n, z, p} = 3'b000;
        #1;
        chk("reset_zero_t0", 64'(dut_v), 64'd0);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("fetch_ir_ld", 64'({dut_v.IR_ld, dut_v.PC_inc, dut_v.addr_MEM_sel}), 64'(4'b1100));

        // ADD R1,R1,#1
        ir = 16'h1261;
        tick();
        chk("add_decode_idle", 64'(dut_v), 64'd0);
        tick();
        chk("add_exec_wen", 64'({dut_v.w_en_RF, dut_v.w_addr_RF, dut_v.B_sel}), 64'(5'b1_001_1));
        chk("add_exec_flags", 64'({dut_v.N_ld, dut_v.Z_ld, dut_v.P_ld, dut_v.w_RF_sel}), 64'(5'b111_10));
        tick();
        chk("add_cycle4_fetch", 64'(dut_v.IR_ld), 64'd1);

        // BRz taken / not taken
        ir = 16'h0402; {n, z, p} = 3'b010;
        tick(); tick();
        chk("brz_taken", 64'({dut_v.PC_ld, dut_v.PC_add_sel, dut_v.PC_data_sel}), 64'(3'b110));
        tick();
        ir = 16'h0402; {n, z, p} = 3'b100;
        tick(); tick();
        chk("brz_not_taken", 64'(dut_v.PC_ld), 64'd0);
        tick();

        // LDI R1: EXEC then EXEC2
        ir = 16'hA201;
        tick(); tick();
        chk("ldi_exec", 64'({dut_v.store_ld, dut_v.addr_MEM_sel, dut_v.sext_sel}), 64'(5'b1_01_10));
        tick();
        chk("ldi_exec2", 64'({dut_v.addr_MEM_sel, dut_v.w_RF_sel, dut_v.NZP_sel, dut_v.w_en_RF}), 64'(6'b10_01_1_1));
        tick();
        chk("ldi_cycle5_fetch", 64'(dut_v.IR_ld), 64'd1);

        // JSRR R7
        ir = 16'h41C0;
        tick(); tick();
        chk("jsrr_r7", 64'({dut_v.w_addr_RF, dut_v.PC_data_sel, dut_v.r_addr_0_RF, dut_v.PC_ld, dut_v.w_en_RF}),
            64'(9'b111_1_111_1_1));
        tick();

        // Remaining opcodes through the model
        run(16'h2205, 3'b000, 3);
        run(16'h3405, 3'b000, 3);
        run(16'hB602, 3'b000, 4);
        run(16'h6A46, 3'b000, 3);
        run(16'h7A46, 3'b000, 3);
        run(16'h5283, 3'b000, 3);
        run(16'h5AA5, 3'b000, 3);
        run(16'h967F, 3'b000, 3);
        run(16'hE3FF, 3'b000, 3);
        run(16'hC080, 3'b000, 3);
        run(16'h4800, 3'b000, 3);
        run(16'h0E00, 3'b001, 3);
        run(16'h0800, 3'b001, 3);
        run(16'hF020, 3'b000, 3);
        run(16'h8000, 3'b000, 3);

`ifdef PUNC_ILLEGAL_TRAP_EN
        ir = 16'hD000;
        tick(); tick();
        chk("reserved_halts", 64'({halted, illegal_op}), 64'(2'b11));
        repeat (3) tick();
        do_reset();
`else
        run(16'hD000, 3'b000, 3);
`endif

        // HALT trap: sticky for 20 cycles, then async reset mid-HALT
        ir = 16'hF025;
        tick(); tick();
        chk("halt_entered", 64'(dut_v.halted), 64'd1);
        repeat (20) tick();
        chk("halt_sticky", 64'(dut_v), 64'(34'h1));
        do_reset();

        run(16'h1261, 3'b000, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
